sba_bus_responder: RTL and testbench
====================================

Name: sba_bus_responder

Overview:
- Bus responder (slave) for the debug module's System Bus Access master port: master_req/we/addr/wdata/be in; gnt, r_valid, r_err, r_other_err, r_rdata out.
- Backed by a word-addressed local RAM window.
- Has programmable grant and response latency, plus address/byte-enable error generation.
- Used as the SBA target in subsystem benches and as a small debug-visible scratch memory in FPGA builds.

Parameters:
- BusWidth, 32, data/address width; must be 32 or 64.
- MemWords, 256, RAM depth in BusWidth words; power of two.
- BaseAddr, 'h8000_0000, first byte address of the window; aligned to MemWords*BusWidth/8.
- GntDelay, 0, cycles req_i must be held before gnt_o asserts (0..15).
- RespLatency, 1, cycles from acceptance edge to r_valid_o (1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; asynchronous and active-high.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  BusWidth  byte address.
- wdata_i  in  BusWidth  write data.
- be_i  in  BusWidth/8  byte enables.
- gnt_o  out  1  request accepted this cycle (combinational).
- r_valid_o  out  1  response valid, one-cycle pulse.
- r_err_o  out  1  bus error (address outside window).
- r_other_err_o  out  1  other error (be_i all zero); has priority over r_err_o.
- r_rdata_o  out  BusWidth  read data.
- busy_o  out  1  transaction outstanding.

Behaviour:
- States: IDLE, WAIT_GNT, RESP. At most one outstanding transaction.
- Reset values: state IDLE; wait_cnt 0; lat_cnt 0; r_valid_o, r_err_o, r_other_err_o, busy_o = 0; r_rdata_o = 0. RAM contents are not reset.
- Grant:
  - gnt_o = req_i && state in {IDLE, WAIT_GNT} && wait_cnt == GntDelay.
  - IDLE with req_i and GntDelay > 0 → WAIT_GNT; wait_cnt increments each cycle while req_i is held.
  - req_i dropped before grant: wait_cnt ← 0, state → IDLE, no transaction.
  - GntDelay = 0: grant in the same cycle req_i rises.
- Acceptance (clock edge with req_i && gnt_o):
  - Latch we/addr/wdata/be and compute the error class.
  - other_err if be_i == 0; else err if addr_i is outside [BaseAddr, BaseAddr + MemWords*BusWidth/8).
  - Error-free write: RAM bytes with be_i[k] = 1 updated at this edge.
  - Error-free read: RAM word captured at this edge; word index = (addr_i − BaseAddr) >> log2(BusWidth/8), low address bits ignored.
  - State → RESP, lat_cnt ← RespLatency − 1, busy_o ← 1, wait_cnt ← 0.
- RESP:
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0, r_valid_o is registered high for exactly one cycle, i.e. the cycle starting RespLatency edges after acceptance.
  - Same cycle as r_valid_o: r_err_o and r_other_err_o are valid and mutually exclusive (other_err wins). r_rdata_o = captured word for an error-free read, else 0.
  - Next state IDLE; busy_o clears with r_valid_o.
  - gnt_o = 0 for the whole of RESP, including the r_valid cycle. Back-to-back throughput is 1 transaction per (GntDelay + RespLatency + 1) cycles.
- r_rdata_o, r_err_o and r_other_err_o return to 0 in the cycle after r_valid_o.
- Errored transactions never modify RAM.
- Reset mid-operation: outstanding transaction discarded, no r_valid_o is generated. A write already committed at acceptance remains in RAM.
- Read-after-write to the same address in consecutive transactions returns the new data.

Optional Feature:
- SBA_RESP_ERR_INJECT_EN defined: adds port err_inject_i (in, 1).
  - If high on the acceptance edge, the response reports r_err_o = 1 (unless other_err applies) and the RAM is not written.
- Undefined: port absent; errors come only from address/be checks.

Decomposition:
- Package sba_resp_pkg:
  - state enum encoding (IDLE = 2'd0, WAIT_GNT = 2'd1, RESP = 2'd2);
  - error-class localparams (ERR_NONE, ERR_BUS, ERR_OTHER);
  - helper constant BYTES_PER_WORD.
- One natural sub-module: sba_resp_ram, single-port byte-enable RAM (MemWords × BusWidth, synchronous write, read captured on acceptance). FSM and checks stay in the top.

Test Plan:
- GntDelay = 0, RespLatency = 1: write 0xDEADBEEF, be = 4'hF to 0x8000_0010, then read 0x8000_0010 → gnt same cycle as req; r_valid 1 cycle after each acceptance; read rdata = 0xDEADBEEF, both errors 0.
- Partial write be = 4'b0101, data 0x11223344 over 0xDEADBEEF at 0x8000_0010 → subsequent read returns 0xDE22BE44.
- Read 0x7FFF_FFFC and 0x8000_0400 (MemWords = 256) → r_err = 1, rdata = 0. Write to 0x8000_0400 leaves RAM unchanged.
- be = 0 to an out-of-range address → r_other_err = 1, r_err = 0, rdata = 0.
- GntDelay = 3, RespLatency = 4: hold req → gnt on 4th cycle of req; r_valid exactly 4 cycles after acceptance. Drop req after 2 cycles → no gnt, no response, next req waits 3 again.
- Assert rst_i 2 cycles after acceptance of a read (RespLatency = 4) → no r_valid_o, busy_o = 0, state IDLE. Prior committed write still readable after reset.

Source files
------------

// File: rtl/sba_resp_pkg.sv
// Shared types and constants for the SBA bus responder: FSM state encoding,
// response error classes and the bytes-per-word helper.
package sba_resp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RESP     = 2'd2
  } sba_state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BUS   = 2'd1;
  localparam logic [1:0] ERR_OTHER = 2'd2;

  // The BYTES_PER_WORD constant for a given bus width.
  function automatic int bytes_per_word(input int bus_w);
    return bus_w / 8;
  endfunction

endpackage

// File: rtl/sba_resp_ram.sv
// Single-port byte-enable RAM behind the SBA responder window. The write is
// committed and the read word captured on the acceptance edge.
module sba_resp_ram
  import sba_resp_pkg::*;
#(
  parameter int BusWidth = 32,
  parameter int MemWords = 256
) (
  input  logic                        clk_i,
  input  logic                        wr_en_i,
  input  logic                        rd_en_i,
  input  logic [$clog2(MemWords)-1:0] idx_i,
  input  logic [BusWidth-1:0]         wdata_i,
  input  logic [BusWidth/8-1:0]       be_i,
  output logic [BusWidth-1:0]         rdata_o
);

  localparam int BPW = bytes_per_word(BusWidth);

  logic [BusWidth-1:0] mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < BPW; k++) begin
        if (be_i[k]) mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (rd_en_i) rdata_o <= mem[idx_i];
  end

endmodule

// File: rtl/sba_bus_responder.sv
// SBA bus responder: programmable grant/response latency over a local RAM window.
// Optional build macro SBA_RESP_ERR_INJECT_EN adds err_inject_i to force bus errors.
module sba_bus_responder
  import sba_resp_pkg::*;
#(
  parameter int                  BusWidth    = 32,
  parameter int                  MemWords    = 256,
  parameter logic [BusWidth-1:0] BaseAddr    = BusWidth'('h8000_0000),
  parameter int                  GntDelay    = 0,
  parameter int                  RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   addr_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
`ifdef SBA_RESP_ERR_INJECT_EN
  input  logic                  err_inject_i,
`endif
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic                  r_err_o,
  output logic                  r_other_err_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  busy_o
);

  localparam int                  BYTES_PER_WORD = bytes_per_word(BusWidth);
  localparam int                  OFF_W          = $clog2(BYTES_PER_WORD);
  localparam int                  IDX_W          = $clog2(MemWords);
  localparam logic [BusWidth-1:0] WIN_BYTES      = BusWidth'(MemWords * BYTES_PER_WORD);
  localparam logic [3:0]          GNT_DLY        = 4'(GntDelay);
  localparam logic [3:0]          LAT_M1         = 4'(RespLatency - 1);

  sba_state_e          state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                r_valid_q, r_valid_d;
  logic                busy_q, busy_d;
  logic [1:0]          err_q, err_d;
  logic                rd_ok_q, rd_ok_d;
  logic                accept;
  logic                inject;
  logic                in_win;
  logic [1:0]          err_class;
  logic [BusWidth-1:0] offset;
  logic [BusWidth-1:0] ram_rdata;

`ifdef SBA_RESP_ERR_INJECT_EN
  assign inject = err_inject_i;
`else
  assign inject = 1'b0;
`endif

  assign offset = addr_i - BaseAddr;
  assign in_win = (addr_i >= BaseAddr) && (offset < WIN_BYTES);

  // Missing byte enables outrank every other error source.
  always_comb begin
    err_class = ERR_NONE;
    if (be_i == '0)            err_class = ERR_OTHER;
    else if (!in_win || inject) err_class = ERR_BUS;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    r_valid_d  = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    rd_ok_d    = rd_ok_q;
    gnt_o      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE, WAIT_GNT: begin
        if (!req_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == GNT_DLY) begin
          gnt_o      = 1'b1;
          accept     = 1'b1;
          state_d    = RESP;
          wait_cnt_d = '0;
          lat_cnt_d  = LAT_M1;
          busy_d     = 1'b1;
          r_valid_d  = (LAT_M1 == 4'd0);
          err_d      = err_class;
          rd_ok_d    = (err_class == ERR_NONE) && !we_i;
        end else begin
          state_d    = WAIT_GNT;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      RESP: begin
        // r_valid is registered one edge ahead so it lands in the lat_cnt==0 cycle.
        if (lat_cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
          r_valid_d = (lat_cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      r_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= ERR_NONE;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      r_valid_q  <= r_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  sba_resp_ram #(
    .BusWidth (BusWidth),
    .MemWords (MemWords)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en_i (accept && we_i && (err_class == ERR_NONE)),
    .rd_en_i (accept && !we_i && (err_class == ERR_NONE)),
    .idx_i   (offset[OFF_W +: IDX_W]),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .rdata_o (ram_rdata)
  );

  assign r_valid_o     = r_valid_q;
  assign busy_o        = busy_q;
  assign r_err_o       = r_valid_q && (err_q == ERR_BUS);
  assign r_other_err_o = r_valid_q && (err_q == ERR_OTHER);
  assign r_rdata_o     = (r_valid_q && rd_ok_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_sba_bus_responder.sv
// Bench for sba_bus_responder: two instances (GntDelay/RespLatency 0/1 and 3/4)
// checked against a word-array reference model of the responder window.
module tb_sba_bus_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  int n_checks = 0;
  int n_fail   = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        gnt0, rv0, re0, ro0, busy0;
  logic        gnt1, rv1, re1, ro1, busy1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  sba_bus_responder #(.GntDelay(0), .RespLatency(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt0), .r_valid_o(rv0), .r_err_o(re0),
    .r_other_err_o(ro0), .r_rdata_o(rd0), .busy_o(busy0));

  sba_bus_responder #(.GntDelay(3), .RespLatency(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt1), .r_valid_o(rv1), .r_err_o(re1),
    .r_other_err_o(ro1), .r_rdata_o(rd1), .busy_o(busy1));

  // Reference model: one word array per instance
  logic [31:0] mmem [2][256];

  function automatic int exp_g(input int d); return d ? 4 : 1; endfunction
  function automatic int exp_l(input int d); return d ? 4 : 1; endfunction

  function automatic logic gnt_of(input int d);   return d ? gnt1 : gnt0; endfunction
  function automatic logic valid_of(input int d); return d ? rv1 : rv0; endfunction
  function automatic logic err_of(input int d);   return d ? re1 : re0; endfunction
  function automatic logic oerr_of(input int d);  return d ? ro1 : ro0; endfunction
  function automatic logic busy_of(input int d);  return d ? busy1 : busy0; endfunction
  function automatic logic [31:0] rdata_of(input int d); return d ? rd1 : rd0; endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 0) req0 = v; else req1 = v;
  endtask

  function automatic void model(input int d, input logic w, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] b,
      output logic [31:0] rd, output logic e, output logic oe);
    longint off;
    int i;
    off = longint'(a) - longint'(BASE);
    rd = '0; e = 1'b0; oe = 1'b0;
    if (b == 4'h0) oe = 1'b1;
    else if (off < 0 || off >= 1024) e = 1'b1;
    else begin
      i = int'(off / 4);
      if (w) begin
        for (int k = 0; k < 4; k++) if (b[k]) mmem[d][i][8*k +: 8] = wd[8*k +: 8];
      end else rd = mmem[d][i];
    end
  endfunction

  // Drives one transaction; reports grant/response cycle counts, the response
  // fields, and ok=0 if busy dropped early or the response did not clear after.
  task automatic run_txn(input int d, input logic w, input logic [31:0] a,
      input logic [31:0] wd, input logic [3:0] b,
      output int gcyc, output int lcyc, output logic [31:0] rd,
      output logic e, output logic oe, output bit ok);
    @(negedge clk);
    we = w; addr = a; wdata = wd; be = b; set_req(d, 1'b1);
    gcyc = -1; lcyc = -1; rd = 'x; e = 1'bx; oe = 1'bx; ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      #1;
      if (gnt_of(d)) begin gcyc = n; break; end
      @(negedge clk);
    end
    if (gcyc > 0) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (k == 1) set_req(d, 1'b0);
        #1;
        if (!busy_of(d)) ok = 1'b0;
        if (valid_of(d)) begin
          lcyc = k; rd = rdata_of(d); e = err_of(d); oe = oerr_of(d);
          break;
        end
      end
      @(negedge clk); #1;
      if (valid_of(d) || err_of(d) || oerr_of(d) || rdata_of(d) !== 32'h0 || busy_of(d)) ok = 1'b0;
    end else set_req(d, 1'b0);
  endtask

  task automatic test_reset();
    n_checks++;
    if ({gnt0, rv0, re0, ro0, busy0, rd0} !== 37'h0) begin
      n_fail++; $display("FAIL reset_dut0: got %h expected 0", {gnt0, rv0, re0, ro0, busy0, rd0});
    end
    n_checks++;
    if ({gnt1, rv1, re1, ro1, busy1, rd1} !== 37'h0) begin
      n_fail++; $display("FAIL reset_dut1: got %h expected 0", {gnt1, rv1, re1, ro1, busy1, rd1});
    end
  endtask

  task automatic test_basic();
    int g, l; logic [31:0] rd, mrd; logic e, oe, me, moe; bit ok;
    model(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, mrd, me, moe);
    run_txn(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({g, l} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL basic_wr_timing: got gnt %0d lat %0d expected 1 1", g, l);
    end
    n_checks++;
    if ({e, oe, ok} !== 3'b001) begin
      n_fail++; $display("FAIL basic_wr_status: got err %b oerr %b ok %b expected 0 0 1", e, oe, ok);
    end
    model(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, mrd, me, moe);
    run_txn(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({g, l} !== {32'd1, 32'd1}) begin
      n_fail++; $display("FAIL basic_rd_timing: got gnt %0d lat %0d expected 1 1", g, l);
    end
    n_checks++;
    if ({e, oe, ok, rd} !== {3'b001, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL basic_rd_data: got %b%b%b %h expected 001 deadbeef", e, oe, ok, rd);
    end
  endtask

  task automatic test_partial();
    int g, l; logic [31:0] rd, mrd; logic e, oe, me, moe; bit ok;
    model(0, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, mrd, me, moe);
    run_txn(0, 1'b1, BASE + 32'h10, 32'h11223344, 4'b0101, g, l, rd, e, oe, ok);
    model(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, mrd, me, moe);
    run_txn(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({e, oe, ok, rd} !== {3'b001, 32'hDE22BE44}) begin
      n_fail++; $display("FAIL partial_write: got %b%b%b %h expected 001 de22be44", e, oe, ok, rd);
    end
  endtask

  typedef struct packed {
    logic w; logic [31:0] a; logic [31:0] wd; logic [3:0] b;
    logic e; logic oe; logic [31:0] rd;
  } row_t;
  row_t rows[11];

  task automatic test_errors();
    int g, l; logic [31:0] rd, mrd; logic e, oe, me, moe; bit ok;
    rows[0]  = '{1'b1, BASE,           32'h55AA55AA, 4'hF, 1'b0, 1'b0, 32'h0};
    rows[1]  = '{1'b0, 32'h7FFFFFFC,   32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    rows[2]  = '{1'b0, 32'h80000400,   32'h0,        4'hF, 1'b1, 1'b0, 32'h0};
    rows[3]  = '{1'b1, 32'h80000400,   32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0};
    rows[4]  = '{1'b0, BASE,           32'h0,        4'hF, 1'b0, 1'b0, 32'h55AA55AA};
    rows[5]  = '{1'b1, 32'h800003FC,   32'h0BADF00D, 4'hF, 1'b0, 1'b0, 32'h0};
    rows[6]  = '{1'b0, 32'h800003FF,   32'h0,        4'hF, 1'b0, 1'b0, 32'h0BADF00D};
    rows[7]  = '{1'b1, 32'h90000000,   32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h0};
    rows[8]  = '{1'b0, 32'h90000000,   32'h0,        4'h0, 1'b0, 1'b1, 32'h0};
    rows[9]  = '{1'b1, BASE,           32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h0};
    rows[10] = '{1'b0, BASE + 32'h2,   32'h0,        4'h1, 1'b0, 1'b0, 32'h55AA55AA};
    for (int i = 0; i < 11; i++) begin
      model(0, rows[i].w, rows[i].a, rows[i].wd, rows[i].b, mrd, me, moe);
      run_txn(0, rows[i].w, rows[i].a, rows[i].wd, rows[i].b, g, l, rd, e, oe, ok);
      n_checks++;
      if ({g, l, e, oe, ok, rd} !== {32'd1, 32'd1, rows[i].e, rows[i].oe, 1'b1, rows[i].rd}) begin
        n_fail++;
        $display("FAIL errors_row%0d: got g%0d l%0d e%b oe%b ok%b rd %h expected e%b oe%b rd %h",
                 i, g, l, e, oe, ok, rd, rows[i].e, rows[i].oe, rows[i].rd);
      end
    end
  endtask

  task automatic test_gnt_delay();
    int g, l; logic [31:0] rd, mrd; logic e, oe, me, moe; bit ok; bit seen;
    model(1, 1'b1, BASE + 32'h80, 32'hA5A50001, 4'hF, mrd, me, moe);
    run_txn(1, 1'b1, BASE + 32'h80, 32'hA5A50001, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({g, l, e, oe, ok} !== {32'd4, 32'd4, 3'b001}) begin
      n_fail++; $display("FAIL gnt_delay_write: got g%0d l%0d e%b oe%b ok%b expected g4 l4 001", g, l, e, oe, ok);
    end
    seen = 1'b0;
    @(negedge clk);
    we = 1'b0; addr = BASE + 32'h80; be = 4'hF; req1 = 1'b1;
    #1; if (gnt1) seen = 1'b1;
    @(negedge clk); #1; if (gnt1) seen = 1'b1;
    @(negedge clk); req1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1; if (gnt1 || rv1 || busy1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL gnt_abort: got activity %b expected 0", seen);
    end
    model(1, 1'b0, BASE + 32'h80, 32'h0, 4'hF, mrd, me, moe);
    run_txn(1, 1'b0, BASE + 32'h80, 32'h0, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({g, l, e, oe, ok, rd} !== {32'd4, 32'd4, 3'b001, 32'hA5A50001}) begin
      n_fail++; $display("FAIL gnt_delay_read: got g%0d l%0d ok%b rd %h expected g4 l4 ok1 a5a50001", g, l, ok, rd);
    end
  endtask

  task automatic test_back_to_back(input int d, input logic [31:0] a);
    int p; logic [31:0] gm, vm, egm, evm, mrd; logic me, moe;
    p = exp_g(d) - 1 + exp_l(d) + 1;
    gm = '0; vm = '0; egm = '0; evm = '0;
    model(d, 1'b0, a, 32'h0, 4'hF, mrd, me, moe);
    @(negedge clk);
    we = 1'b0; addr = a; be = 4'hF; set_req(d, 1'b1);
    for (int t = 0; t < 3 * p; t++) begin
      #1;
      gm[t] = gnt_of(d);
      vm[t] = valid_of(d);
      if (t % p == exp_g(d) - 1) egm[t] = 1'b1;
      if (t % p == exp_g(d) - 1 + exp_l(d)) evm[t] = 1'b1;
      if (valid_of(d)) begin
        n_checks++;
        if ({err_of(d), oerr_of(d), rdata_of(d)} !== {2'b00, mrd}) begin
          n_fail++; $display("FAIL b2b_data_dut%0d: got %h expected %h", d, rdata_of(d), mrd);
        end
      end
      @(negedge clk);
    end
    set_req(d, 1'b0);
    n_checks++;
    if (gm !== egm) begin
      n_fail++; $display("FAIL b2b_gnt_dut%0d: got %h expected %h", d, gm, egm);
    end
    n_checks++;
    if (vm !== evm) begin
      n_fail++; $display("FAIL b2b_valid_dut%0d: got %h expected %h", d, vm, evm);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int g, l; logic [31:0] rd, mrd; logic e, oe, me, moe; bit ok; bit seen; bit granted;
    model(1, 1'b1, BASE + 32'h40, 32'hCAFEF00D, 4'hF, mrd, me, moe);
    run_txn(1, 1'b1, BASE + 32'h40, 32'hCAFEF00D, 4'hF, g, l, rd, e, oe, ok);
    @(negedge clk);
    we = 1'b0; addr = BASE + 32'h40; be = 4'hF; req1 = 1'b1; granted = 1'b0;
    for (int n = 0; n < 10; n++) begin
      #1; if (gnt1) begin granted = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (granted !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_gnt: got %b expected 1", granted);
    end
    @(negedge clk); req1 = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++;
    if ({busy1, rv1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_busy: got %b expected 00", {busy1, rv1});
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1; if (rv1 || busy1) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_noresp: got %b expected 0", seen);
    end
    run_txn(1, 1'b0, BASE + 32'h40, 32'h0, 4'hF, g, l, rd, e, oe, ok);
    n_checks++;
    if ({g, l, e, oe, ok, rd} !== {32'd4, 32'd4, 3'b001, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL reset_mid_keep: got g%0d l%0d ok%b rd %h expected cafef00d", g, l, ok, rd);
    end
  endtask

  task automatic test_random(input int d, input int n);
    int g, l; logic [31:0] rd, mrd, a, wd; logic e, oe, me, moe, w; logic [3:0] b; bit ok;
    for (int i = 0; i < 16 + n; i++) begin
      if (i < 16) begin
        w = 1'b1; a = BASE + 32'(i * 4); wd = $urandom; b = 4'hF;
      end else begin
        w = 1'($urandom % 2);
        wd = $urandom;
        b = ($urandom % 6 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        case ($urandom % 8)
          0: a = BASE + 32'h400 + ($urandom % 32'h1000);
          1: a = BASE - 32'd1 - ($urandom % 32'h1000);
          default: a = BASE + 32'(($urandom % 16) * 4) + ($urandom % 4);
        endcase
      end
      model(d, w, a, wd, b, mrd, me, moe);
      run_txn(d, w, a, wd, b, g, l, rd, e, oe, ok);
      n_checks++;
      if ({g, l} !== {exp_g(d), exp_l(d)}) begin
        n_fail++; $display("FAIL rand_timing_dut%0d_%0d: got g%0d l%0d expected g%0d l%0d", d, i, g, l, exp_g(d), exp_l(d));
      end
      n_checks++;
      if ({e, oe, rd} !== {me, moe, mrd}) begin
        n_fail++; $display("FAIL rand_resp_dut%0d_%0d: addr %h got e%b oe%b rd %h expected e%b oe%b rd %h",
                           d, i, a, e, oe, rd, me, moe, mrd);
      end
      n_checks++;
      if (ok !== 1'b1) begin
        n_fail++; $display("FAIL rand_busy_clear_dut%0d_%0d: got %b expected 1", d, i, ok);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_basic();
    test_partial();
    test_errors();
    test_gnt_delay();
    test_back_to_back(0, BASE + 32'h10);
    test_back_to_back(1, BASE + 32'h80);
    test_reset_mid();
    test_random(0, 40);
    test_random(1, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
